// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL
// Handshaked request/response; status flags and carry_q are registered with the result.
module mc_alu #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              zero_flag,
  output logic              negative_flag,
  output logic              carry_flag,
  output logic              overflow_flag,
  output logic              illegal_op
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_INV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic   accept;
  logic   carry_q;

  logic [DATA_W-1:0] mul_a, mul_hi, mul_lo;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_next, mul_lo_next;
  logic              mul_last;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_ill;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   shl_ext, shr_ext;
  logic signed [DATA_W:0] asr_ext;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = operand_b[SHAMT_W-1:0];

  // One shift-add step: add multiplicand if multiplier LSB set, then shift {sum, lo} right.
  assign mul_sum     = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : '0);
  assign mul_hi_next = mul_sum[DATA_W:1];
  assign mul_lo_next = {mul_sum[0], mul_lo[DATA_W-1:1]};
  assign mul_last    = (state == BUSY) && (mul_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (op == OP_MUL) ? BUSY : DONE;
      BUSY: if (mul_last) state_next = DONE;
      DONE: begin
        if (accept)         state_next = (op == OP_MUL) ? BUSY : DONE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    sum_ext = '0;
    // One guard bit on each shift catches the last bit shifted out.
    shl_ext = {1'b0, operand_a} << shamt;
    shr_ext = {operand_a, 1'b0} >> shamt;
    asr_ext = $signed({operand_a, 1'b0}) >>> shamt;
    case (op)
      OP_ADD, OP_ADC: begin
        sum_ext = {1'b0, operand_a} + {1'b0, operand_b}
                + {{DATA_W{1'b0}}, (op == OP_ADC) & carry_q};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (operand_a[MSB] == operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        sum_ext = {1'b0, operand_a} - {1'b0, operand_b}
                - {{DATA_W{1'b0}}, (op == OP_SBC) & carry_q};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (operand_a[MSB] != operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
      end
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_XOR: alu_res = operand_a ^ operand_b;
      OP_INV: alu_res = ~operand_a;
      OP_SHL: begin
        alu_res = shl_ext[DATA_W-1:0];
        alu_c   = shl_ext[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_ext[DATA_W:1];
        alu_c   = shr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[DATA_W:1];
        alu_c   = asr_ext[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q       <= 1'b0;
      result        <= '0;
      result_hi     <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
      mul_a         <= '0;
      mul_hi        <= '0;
      mul_lo        <= '0;
      mul_cnt       <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mul_a   <= operand_a;
        mul_hi  <= '0;
        mul_lo  <= operand_b;
        mul_cnt <= '0;
      end else begin
        result        <= alu_res;
        result_hi     <= '0;
        zero_flag     <= (alu_res == '0) && !alu_ill;
        negative_flag <= alu_res[MSB];
        carry_flag    <= alu_c;
        overflow_flag <= alu_v;
        illegal_op    <= alu_ill;
        if (!alu_ill) carry_q <= alu_c;
      end
    end else if (state == BUSY) begin
      mul_hi  <= mul_hi_next;
      mul_lo  <= mul_lo_next;
      mul_cnt <= mul_cnt + 1'b1;
      if (mul_last) begin
        result        <= mul_lo_next;
        result_hi     <= mul_hi_next;
        zero_flag     <= ({mul_hi_next, mul_lo_next} == '0);
        negative_flag <= mul_hi_next[MSB];
        carry_flag    <= 1'b0;
        overflow_flag <= (mul_hi_next != '0);
        illegal_op    <= 1'b0;
        carry_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - self-checking bench for mc_alu with a behavioural reference model
module tb_mc_alu;
  localparam int W  = 8;
  localparam int M  = 1 << W;
  localparam int H  = 1 << (W - 1);
  localparam int SM = 1 << $clog2(W);

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic z;
    logic n;
    logic c;
    logic v;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op;
  logic [W-1:0] operand_a, operand_b, result, result_hi;
  logic zero_flag, negative_flag, carry_flag, overflow_flag, illegal_op;
  exp_t got;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cq        = 0;

  mc_alu #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero_flag(zero_flag), .negative_flag(negative_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  assign got = {result, result_hi, zero_flag, negative_flag, carry_flag, overflow_flag, illegal_op};

  function automatic int sgn(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  function automatic logic out_rng(input int s);
    return (s > H - 1) || (s < -H);
  endfunction

  function automatic exp_t model(input int o, input int a, input int b, input int cin);
    exp_t e;
    int full, s;
    longint prod;
    e = '0;
    s = b % SM;
    case (o)
      0: begin full = a + b;       e.res = W'(full); e.c = full >= M; e.v = out_rng(sgn(a) + sgn(b)); end
      1: begin full = a - b;       e.res = W'(full); e.c = a < b;     e.v = out_rng(sgn(a) - sgn(b)); end
      2: begin full = a + b + cin; e.res = W'(full); e.c = full >= M; e.v = out_rng(sgn(a) + sgn(b) + cin); end
      3: begin full = a - b - cin; e.res = W'(full); e.c = full < 0;  e.v = out_rng(sgn(a) - sgn(b) - cin); end
      4: e.res = W'(a & b);
      5: e.res = W'(a | b);
      6: e.res = W'(a ^ b);
      7: e.res = W'(M - 1 - a);
      8: begin full = a * (1 << s); e.res = W'(full); e.c = ((full / M) % 2) == 1; end
      9: begin
        e.res = W'(a / (1 << s));
        e.c = (s == 0) ? 1'b0 : (((a / (1 << (s - 1))) % 2) == 1);
      end
      10: begin
        e.res = W'(sgn(a) >>> s);
        e.c = (s == 0) ? 1'b0 : (((a / (1 << (s - 1))) % 2) == 1);
      end
      11: begin
        prod  = longint'(a) * longint'(b);
        e.res = W'(prod);
        e.hi  = W'(prod / M);
        e.z   = (prod == 0);
        e.n   = e.hi[W-1];
        e.v   = prod >= M;
      end
      default: e.ill = 1'b1;
    endcase
    if (o <= 10) begin
      e.z = (e.res == '0);
      e.n = e.res[W-1];
    end
    return e;
  endfunction

  task automatic apply(input int o, input int a, input int b);
    op        = 4'(o);
    operand_a = W'(a);
    operand_b = W'(b);
    in_valid  = 1'b1;
  endtask

  task automatic run_op(input int o, input int a, input int b, output exp_t obs, output int lat);
    @(negedge clk);
    apply(o, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    obs = got;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    apply(0, 1, 2);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (got !== exp_t'(0)) $display("FAIL reset_outputs: got %h want 0", got); else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_priority: got out_valid %b want 0", out_valid); else pass_cnt++;
    cq = 0;
  endtask

  task automatic test_directed;
    int d_op[7]  = '{0, 0, 2, 1, 3, 11, 13};
    int d_a[7]   = '{'hFF, 'h7F, 'h00, 'h00, 'h05, 'hFF, 'h12};
    int d_b[7]   = '{'h01, 'h01, 'h00, 'h01, 'h01, 'hFF, 'h34};
    int d_lat[7] = '{1, 1, 1, 1, 1, 9, 1};
    exp_t d_exp[7];
    exp_t obs;
    int lat;
    d_exp[0] = {8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    d_exp[1] = {8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_exp[2] = {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    d_exp[3] = {8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    d_exp[4] = {8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    d_exp[5] = {8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_exp[6] = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], obs, lat);
      total_cnt++;
      if (lat !== d_lat[i]) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, d_lat[i]); else pass_cnt++;
      total_cnt++;
      if (obs !== d_exp[i]) $display("FAIL directed%0d_outputs: got %h want %h", i, obs, d_exp[i]); else pass_cnt++;
      if (!d_exp[i].ill) cq = int'(d_exp[i].c);
    end
  endtask

  task automatic test_backpressure;
    exp_t first, second;
    first = {8'hC0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    apply(10, 'h81, 1);
    out_ready = 1'b0;
    @(negedge clk);
    cq = 1;
    second = model(0, 1, 2, cq);
    apply(0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL hold%0d_out_valid: got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++;
      if (got !== first) $display("FAIL hold%0d_outputs: got %h want %h", i, got, first); else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready: got %b want 0", i, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || got !== second)
      $display("FAIL b2b_after_hold: got valid %b out %h want valid 1 out %h", out_valid, got, second);
    else pass_cnt++;
    cq = int'(second.c);
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    int o;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total_cnt++;
        if (out_valid !== 1'b1 || got !== q[0])
          $display("FAIL b2b%0d: got valid %b out %h want valid 1 out %h", i, out_valid, got, q[0]);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready: got %b want 1", i, in_ready); else pass_cnt++;
        void'(q.pop_front());
      end
      if (i < 12) begin
        int a, b;
        o = int'($urandom_range(0, 14));
        if (o >= 11) o++;
        a = int'($urandom_range(0, M - 1));
        b = int'($urandom_range(0, M - 1));
        q.push_back(model(o, a, b, cq));
        if (!q[$].ill) cq = int'(q[$].c);
        apply(o, a, b);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    exp_t e, obs;
    int o, a, b, lat;
    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, M - 1));
      b = int'($urandom_range(0, M - 1));
      e = model(o, a, b, cq);
      run_op(o, a, b, obs, lat);
      total_cnt++;
      if (lat !== ((o == 11) ? W + 1 : 1))
        $display("FAIL rand%0d_latency op %0d: got %0d want %0d", i, o, lat, (o == 11) ? W + 1 : 1);
      else pass_cnt++;
      total_cnt++;
      if (obs !== e) $display("FAIL rand%0d op %0d a %h b %h: got %h want %h", i, o, a, b, obs, e); else pass_cnt++;
      if (!e.ill) cq = int'(e.c);
    end
  endtask

  task automatic test_reset_abort;
    exp_t obs, e;
    int lat, seen;
    run_op(1, 0, 1, obs, lat);
    cq = 1;
    @(negedge clk);
    apply(11, int'($urandom_range(1, M - 1)), int'($urandom_range(1, M - 1)));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cq = 0;
    total_cnt++;
    if (got !== exp_t'(0) || in_ready !== 1'b1)
      $display("FAIL abort_reset_state: got %h ready %b want 0 ready 1", got, in_ready);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (seen != 0) $display("FAIL abort_no_out_valid: got %0d pulses want 0", seen); else pass_cnt++;
    e = {8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_op(3, 5, 1, obs, lat);
    total_cnt++;
    if (obs !== e) $display("FAIL abort_carry_cleared: got %h want %h", obs, e); else pass_cnt++;
    e = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_op(13, 'hA5, 'h5A, obs, lat);
    total_cnt++;
    if (obs !== e || lat !== 1) $display("FAIL abort_illegal: got %h lat %0d want %h lat 1", obs, lat, e); else pass_cnt++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    operand_a = '0;
    operand_b = '0;
    out_ready = 1'b1;
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_reset_abort;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
